bcd_digit_serializer: RTL

- Read-side companion to the 12-bit BCD result register in the BCD adder datapath.
- Accepts one parallel packed-BCD word (NDIG digits, 4 bits each) through a valid/ready handshake.
- Emits the word one digit per transfer, most-significant digit first, on a valid/ready stream to a display or serial consumer.
- Flags non-BCD nibbles (values > 9) as they are sent.

---
 rtl/bcd_digit_serializer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/bcd_digit_serializer.sv
// bcd_digit_serializer
//
// Takes one packed-BCD word (NDIG digits, 4 bits each) through a valid/ready
// handshake and streams it out one digit per transfer, most-significant digit
// first. Nibbles above 9 are passed through raw but flagged on out_err.
//
// Optional build macro: BCD_SER_LZ_BLANK_EN
//   Defined   -> leading zeros above digit 0 are emitted as 4'hF with out_blank=1.
//   Undefined -> no blanking logic; out_blank is held at 0 and digits go out raw.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   in_valid   in   parallel word present
//   in_ready   out  block can accept a word
//   in_word    in   packed BCD word, digit k at [4k+3:4k], digit NDIG-1 is MSD
//   out_valid  out  digit fields valid
//   out_ready  in   consumer accepts the digit
//   out_digit  out  digit value (or 4'hF when blanked)
//   out_idx    out  position of current digit, NDIG-1 down to 0
//   out_last   out  current digit is digit 0
//   out_err    out  raw nibble of current digit is 10..15
//   out_blank  out  current digit is a suppressed leading zero
//   busy       out  word held or being sent
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.

module bcd_digit_serializer #(
  parameter int unsigned NDIG = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_digit,
  output logic [2:0]        out_idx,
  output logic              out_last,
  output logic              out_err,
  output logic              out_blank,
  output logic              busy
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  localparam logic [2:0] TopIdx = 3'(NDIG - 1);

  state_e            state_q;
  logic [4*NDIG-1:0] word_q;

`ifdef BCD_SER_LZ_BLANK_EN
  // Set while every digit above the one currently presented is zero.
  logic lz_q;
  logic adv_lz;
  logic [3:0] cur_nib;
`endif

  logic [3:0] acc_nib;
  logic       acc_blank;
  logic [2:0] adv_idx;
  logic [3:0] adv_nib;
  logic       adv_blank;

  // Constant-index mux keeps every part-select static.
  function automatic logic [3:0] nib_at(input logic [4*NDIG-1:0] w, input logic [2:0] idx);
    logic [3:0] r;
    r = 4'h0;
    for (int k = 0; k < int'(NDIG); k++) begin
      if (idx == 3'(k)) begin
        r = w[4*k +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] shown_digit(input logic [3:0] nib, input logic blank);
    return blank ? 4'hF : nib;
  endfunction

  // A blanked digit is a zero, so it can never be an error digit.
  function automatic logic nib_err(input logic [3:0] nib, input logic blank);
    return !blank && (nib > 4'd9);
  endfunction

  always_comb begin
    acc_nib = nib_at(in_word, TopIdx);
    adv_idx = out_idx - 3'd1;
    adv_nib = nib_at(word_q, adv_idx);
`ifdef BCD_SER_LZ_BLANK_EN
    cur_nib   = nib_at(word_q, out_idx);
    acc_blank = (acc_nib == 4'h0) && (TopIdx != 3'd0);
    // Any nonzero nibble, valid or not, ends blanking for the rest of the word.
    adv_lz    = lz_q && (cur_nib == 4'h0);
    adv_blank = adv_lz && (adv_nib == 4'h0) && (adv_idx != 3'd0);
`else
    acc_blank = 1'b0;
    adv_blank = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      word_q    <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_digit <= 4'h0;
      out_idx   <= 3'd0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      out_blank <= 1'b0;
`ifdef BCD_SER_LZ_BLANK_EN
      lz_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            state_q   <= StSend;
            word_q    <= in_word;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_idx   <= TopIdx;
            out_last  <= (TopIdx == 3'd0);
            out_digit <= shown_digit(acc_nib, acc_blank);
            out_err   <= nib_err(acc_nib, acc_blank);
            out_blank <= acc_blank;
`ifdef BCD_SER_LZ_BLANK_EN
            lz_q      <= 1'b1;
`endif
          end
        end
        StSend: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              // Return to idle for one full cycle before the next word.
              state_q   <= StIdle;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              out_idx   <= adv_idx;
              out_last  <= (adv_idx == 3'd0);
              out_digit <= shown_digit(adv_nib, adv_blank);
              out_err   <= nib_err(adv_nib, adv_blank);
              out_blank <= adv_blank;
`ifdef BCD_SER_LZ_BLANK_EN
              lz_q      <= adv_lz;
`endif
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
